// File: rtl/regfile_shadow.sv
// rtl/regfile_shadow.sv - double-buffered LED controller register file
// Staging bank is host-writable; active bank reloads only between frames.
module regfile_shadow #(
  parameter int CHAN_NUM = 8,
  parameter int TIME_W   = 8,
  parameter int LEN_W    = 8,
  localparam int CNT_W   = $clog2(CHAN_NUM)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                reg_wr_en_i,
  input  logic [2:0]          reg_wr_addr_i,
  input  logic [7:0]          reg_wr_data_i,
  input  logic                reg_rd_en_i,
  input  logic [2:0]          reg_rd_addr_i,
  output logic [7:0]          reg_rd_data_o,
  output logic                reg_rd_valid_o,
  input  logic                frame_busy_i,
  output logic [TIME_W-1:0]   reg_t0h_time_o,
  output logic [TIME_W:0]     reg_t0s_time_o,
  output logic [TIME_W-1:0]   reg_t1h_time_o,
  output logic [TIME_W:0]     reg_t1s_time_o,
  output logic [LEN_W-1:0]    reg_chan_len_o,
  output logic [CNT_W-1:0]    reg_chan_cnt_o,
  output logic [CHAN_NUM-1:0] reg_chan_en_o,
  output logic                commit_pending_o,
  output logic                commit_done_o
);

  logic [TIME_W-1:0] stg_t0h_q, stg_t0h_d, stg_t0l_q, stg_t0l_d;
  logic [TIME_W-1:0] stg_t1h_q, stg_t1h_d, stg_t1l_q, stg_t1l_d;
  logic [LEN_W-1:0]  stg_len_q, stg_len_d;
  logic [CNT_W-1:0]  stg_cnt_q, stg_cnt_d;
  logic [TIME_W-1:0] act_t0h_q, act_t0h_d, act_t1h_q, act_t1h_d;
  logic [TIME_W:0]   act_t0s_q, act_t0s_d, act_t1s_q, act_t1s_d;
  logic [LEN_W-1:0]  act_len_q, act_len_d;
  logic [CNT_W-1:0]  act_cnt_q, act_cnt_d;
  logic              auto_q, auto_d, err_q, err_d, pend_q, pend_d;
  logic              done_q, done_d, rd_valid_q, rd_valid_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              wr_stg, set_pend, commit;

  always_comb begin
    stg_t0h_d  = stg_t0h_q;
    stg_t0l_d  = stg_t0l_q;
    stg_t1h_d  = stg_t1h_q;
    stg_t1l_d  = stg_t1l_q;
    stg_len_d  = stg_len_q;
    stg_cnt_d  = stg_cnt_q;
    act_t0h_d  = act_t0h_q;
    act_t0s_d  = act_t0s_q;
    act_t1h_d  = act_t1h_q;
    act_t1s_d  = act_t1s_q;
    act_len_d  = act_len_q;
    act_cnt_d  = act_cnt_q;
    auto_d     = auto_q;
    err_d      = err_q;
    rd_valid_d = reg_rd_en_i;
    rd_data_d  = 8'h00;

    wr_stg   = reg_wr_en_i && (reg_wr_addr_i <= 3'd5);
    commit   = pend_q && !frame_busy_i;
    set_pend = (reg_wr_en_i && (reg_wr_addr_i == 3'd6) && reg_wr_data_i[0]) ||
               (wr_stg && auto_q);

    if (reg_wr_en_i) begin
      case (reg_wr_addr_i)
        3'd0: stg_t0h_d = reg_wr_data_i[TIME_W-1:0];
        3'd1: stg_t0l_d = reg_wr_data_i[TIME_W-1:0];
        3'd2: stg_t1h_d = reg_wr_data_i[TIME_W-1:0];
        3'd3: stg_t1l_d = reg_wr_data_i[TIME_W-1:0];
        3'd4: stg_len_d = reg_wr_data_i[LEN_W-1:0];
        3'd5: begin
          // Saturation compares the whole byte, not just the stored low bits.
          if (reg_wr_data_i > 8'(CHAN_NUM - 1)) begin
            stg_cnt_d = CNT_W'(CHAN_NUM - 1);
            err_d     = 1'b1;
          end else begin
            stg_cnt_d = reg_wr_data_i[CNT_W-1:0];
          end
        end
        3'd6: begin
          auto_d = reg_wr_data_i[1];
          if (reg_wr_data_i[2]) err_d = 1'b0;
        end
        default: err_d = 1'b1;
      endcase
    end

    // Commit uses the pre-write staging contents; a same-edge write stays staged.
    if (commit) begin
      act_t0h_d = stg_t0h_q;
      act_t1h_d = stg_t1h_q;
      act_t0s_d = {1'b0, stg_t0h_q} + {1'b0, stg_t0l_q};
      act_t1s_d = {1'b0, stg_t1h_q} + {1'b0, stg_t1l_q};
      act_len_d = stg_len_q;
      act_cnt_d = stg_cnt_q;
    end
    pend_d = (pend_q && !commit) || set_pend;
    done_d = commit;

    if (reg_rd_en_i) begin
      case (reg_rd_addr_i)
        3'd0:    rd_data_d = 8'(stg_t0h_q);
        3'd1:    rd_data_d = 8'(stg_t0l_q);
        3'd2:    rd_data_d = 8'(stg_t1h_q);
        3'd3:    rd_data_d = 8'(stg_t1l_q);
        3'd4:    rd_data_d = 8'(stg_len_q);
        3'd5:    rd_data_d = 8'(stg_cnt_q);
        3'd6:    rd_data_d = {6'b0, auto_q, 1'b0};
        default: rd_data_d = {6'b0, err_q, pend_q};
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stg_t0h_q  <= '0;
      stg_t0l_q  <= '0;
      stg_t1h_q  <= '0;
      stg_t1l_q  <= '0;
      stg_len_q  <= '0;
      stg_cnt_q  <= '0;
      act_t0h_q  <= '0;
      act_t0s_q  <= '0;
      act_t1h_q  <= '0;
      act_t1s_q  <= '0;
      act_len_q  <= '0;
      act_cnt_q  <= '0;
      auto_q     <= 1'b0;
      err_q      <= 1'b0;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      stg_t0h_q  <= stg_t0h_d;
      stg_t0l_q  <= stg_t0l_d;
      stg_t1h_q  <= stg_t1h_d;
      stg_t1l_q  <= stg_t1l_d;
      stg_len_q  <= stg_len_d;
      stg_cnt_q  <= stg_cnt_d;
      act_t0h_q  <= act_t0h_d;
      act_t0s_q  <= act_t0s_d;
      act_t1h_q  <= act_t1h_d;
      act_t1s_q  <= act_t1s_d;
      act_len_q  <= act_len_d;
      act_cnt_q  <= act_cnt_d;
      auto_q     <= auto_d;
      err_q      <= err_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    reg_chan_en_o = '0;
    for (int i = 0; i < CHAN_NUM; i++) begin
      reg_chan_en_o[i] = (CNT_W'(i) <= act_cnt_q);
    end
  end

  assign reg_t0h_time_o   = act_t0h_q;
  assign reg_t0s_time_o   = act_t0s_q;
  assign reg_t1h_time_o   = act_t1h_q;
  assign reg_t1s_time_o   = act_t1s_q;
  assign reg_chan_len_o   = act_len_q;
  assign reg_chan_cnt_o   = act_cnt_q;
  assign commit_pending_o = pend_q;
  assign commit_done_o    = done_q;
  assign reg_rd_data_o    = rd_data_q;
  assign reg_rd_valid_o   = rd_valid_q;

endmodule

// File: tb/tb_regfile_shadow.sv
// tb/tb_regfile_shadow.sv - scoreboard bench for regfile_shadow
// Stimulus pushes expected reads/commits; a negedge monitor pops and compares.
module tb_regfile_shadow;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0, busy = 1'b0;
  logic [2:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] t0h, t1h, len, en;
  logic [8:0] t0s, t1s;
  logic [2:0] cnt;
  logic       pending, done;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      nm;
    logic [7:0] v;
  } rd_exp_t;

  typedef struct {
    string      nm;
    logic [7:0] t0h;
    logic [8:0] t0s;
    logic [7:0] t1h;
    logic [8:0] t1s;
    logic [7:0] len;
    logic [2:0] cnt;
    logic [7:0] en;
  } cm_exp_t;

  rd_exp_t rdq[$];
  cm_exp_t cmq[$];

  regfile_shadow #(.CHAN_NUM(8), .TIME_W(8), .LEN_W(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .reg_wr_en_i(wr_en), .reg_wr_addr_i(wr_addr), .reg_wr_data_i(wr_data),
    .reg_rd_en_i(rd_en), .reg_rd_addr_i(rd_addr),
    .reg_rd_data_o(rd_data), .reg_rd_valid_o(rd_valid),
    .frame_busy_i(busy),
    .reg_t0h_time_o(t0h), .reg_t0s_time_o(t0s),
    .reg_t1h_time_o(t1h), .reg_t1s_time_o(t1s),
    .reg_chan_len_o(len), .reg_chan_cnt_o(cnt), .reg_chan_en_o(en),
    .commit_pending_o(pending), .commit_done_o(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (rdq.size() == 0) begin
        chk("rd_unexpected", 32'd1, 32'd0);
      end else begin
        rd_exp_t r;
        r = rdq.pop_front();
        chk(r.nm, 32'(rd_data), 32'(r.v));
      end
    end
    if (rst_n && done) begin
      if (cmq.size() == 0) begin
        chk("commit_unexpected", 32'd1, 32'd0);
      end else begin
        cm_exp_t c;
        c = cmq.pop_front();
        chk({c.nm, "_t0h"}, 32'(t0h), 32'(c.t0h));
        chk({c.nm, "_t0s"}, 32'(t0s), 32'(c.t0s));
        chk({c.nm, "_t1h"}, 32'(t1h), 32'(c.t1h));
        chk({c.nm, "_t1s"}, 32'(t1s), 32'(c.t1s));
        chk({c.nm, "_len"}, 32'(len), 32'(c.len));
        chk({c.nm, "_cnt"}, 32'(cnt), 32'(c.cnt));
        chk({c.nm, "_en"},  32'(en),  32'(c.en));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e, input string nm);
    rd_exp_t r;
    r.nm = nm; r.v = e;
    rdq.push_back(r);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic exp_commit(input string nm, input logic [7:0] a, input logic [8:0] b,
                            input logic [7:0] c, input logic [8:0] d, input logic [7:0] l,
                            input logic [2:0] n, input logic [7:0] m);
    cm_exp_t x;
    x.nm = nm; x.t0h = a; x.t0s = b; x.t1h = c; x.t1s = d; x.len = l; x.cnt = n; x.en = m;
    cmq.push_back(x);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_t0h"}, 32'(t0h), 32'h0);
    chk({nm, "_t0s"}, 32'(t0s), 32'h0);
    chk({nm, "_t1h"}, 32'(t1h), 32'h0);
    chk({nm, "_t1s"}, 32'(t1s), 32'h0);
    chk({nm, "_len"}, 32'(len), 32'h0);
    chk({nm, "_cnt"}, 32'(cnt), 32'h0);
    chk({nm, "_en"},  32'(en),  32'h01);
    chk({nm, "_pend"}, 32'(pending), 32'h0);
    chk({nm, "_done"}, 32'(done), 32'h0);
    chk({nm, "_rdv"},  32'(rd_valid), 32'h0);
    chk({nm, "_rdd"},  32'(rd_data), 32'h0);
  endtask

  initial begin
    #12;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) rd(3'(a), 8'h00, $sformatf("rst_rd%0d", a));

    // Basic load and commit
    wr(3'd0, 8'h01); wr(3'd1, 8'h12); wr(3'd2, 8'h23);
    wr(3'd3, 8'h34); wr(3'd4, 8'h3f); wr(3'd5, 8'h07);
    exp_commit("cm1", 8'h01, 9'h013, 8'h23, 9'h057, 8'h3f, 3'd7, 8'hff);
    wr(3'd6, 8'h01);
    chk("cm1_pend_set", 32'(pending), 32'h1);
    tick();
    chk("cm1_applied_t0s", 32'(t0s), 32'h013);
    tick(); tick();

    // Overflow-free sum, plus read racing a write to the same address
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hff;
    begin
      rd_exp_t r;
      r.nm = "rd_pre_write"; r.v = 8'h01;
      rdq.push_back(r);
    end
    rd_en = 1'b1; rd_addr = 3'd0;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    rd(3'd0, 8'hff, "rd_post_write");
    wr(3'd1, 8'hff);
    exp_commit("cm2", 8'hff, 9'h1fe, 8'h23, 9'h057, 8'h3f, 3'd7, 8'hff);
    wr(3'd6, 8'h01);
    tick(); tick();

    // Busy defers the commit
    busy = 1'b1;
    wr(3'd2, 8'h40);
    wr(3'd6, 8'h01);
    tick(); tick();
    rd(3'd7, 8'h01, "busy_status");
    chk("busy_t1h_held", 32'(t1h), 32'h23);
    exp_commit("cm3", 8'hff, 9'h1fe, 8'h40, 9'h074, 8'h3f, 3'd7, 8'hff);
    busy = 1'b0;
    tick();
    chk("unbusy_t1h", 32'(t1h), 32'h40);
    tick();
    rd(3'd7, 8'h00, "after_cm3_status");

    // CHAN_CNT saturation and sticky error
    wr(3'd5, 8'h0c);
    rd(3'd5, 8'h07, "cnt_sat");
    rd(3'd7, 8'h02, "err_set");
    wr(3'd7, 8'h00);
    rd(3'd7, 8'h02, "err_sticky");
    wr(3'd6, 8'h04);
    rd(3'd7, 8'h00, "err_clr");
    rd(3'd6, 8'h00, "ctrl_rd");

    // Auto-commit
    wr(3'd6, 8'h02);
    rd(3'd6, 8'h02, "auto_rd");
    exp_commit("cm_auto", 8'hff, 9'h1fe, 8'h40, 9'h074, 8'h10, 3'd7, 8'hff);
    wr(3'd4, 8'h10);
    tick();
    chk("auto_len", 32'(len), 32'h10);
    tick();

    // Reset while a commit is pending
    busy = 1'b1;
    wr(3'd4, 8'h20);
    rd(3'd7, 8'h01, "pend_before_rst");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    busy = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rd(3'd4, 8'h00, "rst_len_stg");
    rd(3'd6, 8'h00, "rst_ctrl");
    rd(3'd7, 8'h00, "rst_status");
    tick(); tick();
    chk("rst_no_commit_len", 32'(len), 32'h0);

    chk("rd_queue_drained", 32'(rdq.size()), 32'd0);
    chk("cm_queue_drained", 32'(cmq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
